// File: rtl/seq_div.sv
// rtl/seq_div.sv - multi-cycle signed restoring divider (LO = Ra / Rb, HI = Ra % Rb)
// Optional build macro: SEQ_DIV_DIVZERO_EN (div_zero output and short divide-by-zero path).
module seq_div #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] Ra,
  input  logic [WIDTH-1:0] Rb,
  output logic             busy,
  output logic             done,
`ifdef SEQ_DIV_DIVZERO_EN
  output logic             div_zero,
`endif
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] ra_q;
  logic             qneg_q;
  logic             rneg_q;
  logic             dz_q;
`ifdef SEQ_DIV_DIVZERO_EN
  logic             wait_q;
`endif

  logic load;
  logic step;
  logic fix;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] ra_mag;
  logic [WIDTH-1:0] rb_mag;
  logic [WIDTH-1:0] lo_fix;
  logic [WIDTH-1:0] hi_fix;

  // Same two's-complement negation the neg unit uses.
  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  assign ra_mag = Ra[WIDTH-1] ? neg(Ra) : Ra;
  assign rb_mag = Rb[WIDTH-1] ? neg(Rb) : Rb;

  // The remainder stays below the divisor, so WIDTH+1 bits hold the shifted value.
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dvs_q};

  always_comb begin
    lo_fix = qneg_q ? neg(quo_q) : quo_q;
    hi_fix = rneg_q ? neg(rem_q) : rem_q;
    if (dz_q) begin
      lo_fix = '1;
      hi_fix = ra_q;
    end
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load = 1'b1;
`ifdef SEQ_DIV_DIVZERO_EN
          if (Rb == '0) begin
            state_d = FIXUP;
          end else begin
            state_d = RUN;
          end
`else
          state_d = RUN;
`endif
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = FIXUP;
        end
      end
      FIXUP: begin
`ifdef SEQ_DIV_DIVZERO_EN
        // The short zero-divisor path lingers one cycle so done lands two edges after start.
        if (wait_q) begin
          state_d = FIXUP;
        end else begin
          fix     = 1'b1;
          state_d = IDLE;
        end
`else
        fix     = 1'b1;
        state_d = IDLE;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      ra_q     <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      done     <= 1'b0;
      HI       <= '0;
      LO       <= '0;
`ifdef SEQ_DIV_DIVZERO_EN
      wait_q   <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef SEQ_DIV_DIVZERO_EN
      div_zero <= 1'b0;
      if (state_q == FIXUP) begin
        wait_q <= 1'b0;
      end
`endif
      if (load) begin
        rem_q  <= '0;
        quo_q  <= ra_mag;
        dvs_q  <= rb_mag;
        ra_q   <= Ra;
        qneg_q <= Ra[WIDTH-1] ^ Rb[WIDTH-1];
        rneg_q <= Ra[WIDTH-1];
        dz_q   <= (Rb == '0);
        cnt_q  <= CW'(WIDTH);
`ifdef SEQ_DIV_DIVZERO_EN
        wait_q <= (Rb == '0);
`endif
      end
      if (step) begin
        if (!trial[WIDTH]) begin
          rem_q <= trial[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_q <= rem_sh[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_q <= cnt_q - CW'(1);
      end
      if (fix) begin
        LO   <= lo_fix;
        HI   <= hi_fix;
        done <= 1'b1;
`ifdef SEQ_DIV_DIVZERO_EN
        div_zero <= dz_q;
`endif
      end
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// tb/tb_seq_div.sv - directed self-checking bench for seq_div
module tb_seq_div;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [31:0] Ra;
  logic [31:0] Rb;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;
`ifdef SEQ_DIV_DIVZERO_EN
  logic        div_zero;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  seq_div #(.WIDTH(32)) dut (
    .clock    (clock),
    .clear    (clear),
    .start    (start),
    .Ra       (Ra),
    .Rb       (Rb),
    .busy     (busy),
    .done     (done),
`ifdef SEQ_DIV_DIVZERO_EN
    .div_zero (div_zero),
`endif
    .HI       (HI),
    .LO       (LO)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Launches one divide, then counts edges after the start edge until done (bounded).
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int n;
    int nb;
    int lat;
    lat = 33;
`ifdef SEQ_DIV_DIVZERO_EN
    if (b == 32'd0) lat = 2;
`endif
    Ra = a;
    Rb = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    Ra = $urandom;
    Rb = $urandom;
    nb = busy ? 1 : 0;
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
      if (!done && busy) nb++;
    end
    check_eq({tag, "_lat"}, 32'(n), 32'(lat));
    check_eq({tag, "_busy_cycles"}, 32'(nb), 32'(lat));
    check_eq({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_LO"}, LO, exp_lo);
    check_eq({tag, "_HI"}, HI, exp_hi);
`ifdef SEQ_DIV_DIVZERO_EN
    check_eq({tag, "_div_zero"}, {31'd0, div_zero}, {31'd0, (b == 32'd0)});
`endif
  endtask

  initial begin
    int n;
    logic saw;

    clear = 1'b1;
    start = 1'b0;
    Ra = 32'd0;
    Rb = 32'd0;
    tick();
    tick();
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_HI", HI, 32'd0);
    check_eq("rst_LO", LO, 32'd0);
    clear = 1'b0;
    tick();

    run_div("7/2", 32'd7, 32'd2, 32'd3, 32'd1);
    Ra = 32'h1234_5678;
    Rb = 32'h0000_0001;
    tick();
    tick();
    tick();
    check_eq("hold_done", {31'd0, done}, 32'd0);
    check_eq("hold_LO", LO, 32'd3);
    check_eq("hold_HI", HI, 32'd1);

    run_div("m7/2",  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("7/m2",  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    run_div("m8/m2", 32'hFFFF_FFF8, 32'hFFFF_FFFE, 32'd4,         32'd0);
    run_div("ovf",   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    run_div("0/5",   32'd0,         32'd5,         32'd0,         32'd0);
    run_div("100/7", 32'd100,       32'd7,         32'd14,        32'd2);
    run_div("m5/0",  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB);

    // Clear in the middle of a run: nothing posts, results go to zero.
    Ra = 32'd100;
    Rb = 32'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    clear = 1'b1;
    #1;
    check_eq("clr_busy", {31'd0, busy}, 32'd0);
    check_eq("clr_HI", HI, 32'd0);
    check_eq("clr_LO", LO, 32'd0);
    tick();
    tick();
    clear = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) saw = 1'b1;
    end
    check_eq("clr_no_done", {31'd0, saw}, 32'd0);
    check_eq("clr_LO_after", LO, 32'd0);
    run_div("post_clr", 32'd100, 32'd7, 32'd14, 32'd2);

    // start held high: ignored while busy, re-accepted on the edge after done.
    Ra = 32'd9;
    Rb = 32'd3;
    start = 1'b1;
    tick();
    Ra = 32'd10;
    Rb = 32'd4;
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    check_eq("held1_lat", 32'(n), 32'd33);
    check_eq("held1_LO", LO, 32'd3);
    check_eq("held1_HI", HI, 32'd0);
    tick();
    check_eq("held2_busy", {31'd0, busy}, 32'd1);
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    check_eq("held2_lat", 32'(n), 32'd33);
    check_eq("held2_LO", LO, 32'd2);
    check_eq("held2_HI", HI, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_div.md
Name: seq_div

Overview:
- Multi-cycle signed 32-bit restoring divider for the Phase 1 ALU datapath.
- Computes Ra / Rb: quotient goes to LO, remainder goes to HI, for the DIV instruction.
- Uses the same two's-complement negation rule as the neg unit to form operand magnitudes and to apply result signs.
- Replaces a combinational divide with a start/busy/done handshake so the control unit can stall.

Parameters:
- WIDTH, 32, operand and result width in bits; the iteration count equals WIDTH.

Ports:
- clock  input  1  rising-edge clock
- clear  input  1  asynchronous active-high reset
- start  input  1  request a divide; sampled only in IDLE
- Ra  input  WIDTH  dividend, two's complement; sampled on the start edge
- Rb  input  WIDTH  divisor, two's complement; sampled on the start edge
- busy  output  1  high while a divide is in progress
- done  output  1  one-cycle pulse when HI/LO are updated
- HI  output  WIDTH  remainder
- LO  output  WIDTH  quotient

Behaviour:
- Reset: clear high forces state IDLE at any time, including mid-operation.
  - busy=0, done=0, HI=0, LO=0.
  - Internal accumulator, counter and sign flags are all cleared.
  - No partial result is ever written.
- States: IDLE -> RUN -> FIXUP -> IDLE.
- IDLE, start=1 at an edge (edge 0):
  - capture |Ra| and |Rb| as WIDTH-bit unsigned values;
  - record qneg = Ra[MSB] XOR Rb[MSB], rneg = Ra[MSB], dz = (Rb == 0);
  - set counter = WIDTH, busy=1, go to RUN.
- IDLE, start=0: remain in IDLE; HI/LO hold their values.
- RUN, one restoring step per edge, WIDTH edges in total (edges 1..WIDTH):
  - shift {rem, quo} left by 1;
  - trial = rem - |Rb| using WIDTH+1 bits;
  - if trial is non-negative: rem = trial and the quotient LSB = 1; otherwise the LSB = 0;
  - decrement counter; after the step in which the counter reaches 0, go to FIXUP.
- FIXUP (edge WIDTH+1), normal case:
  - LO = qneg ? -quo : quo;
  - HI = rneg ? -rem : rem (truncating division; the remainder takes the dividend's sign);
  - done=1 for exactly one cycle, busy=0, return to IDLE.
- FIXUP, dz=1: LO = all ones, HI = Ra as originally sampled, independent of operand signs.
- Latency: done is high in the cycle after edge WIDTH+1, which is 33 edges after the start edge when WIDTH=32.
- Overflow: Ra = 0x80000000, Rb = -1 gives LO = 0x80000000, HI = 0. This falls out of the unsigned magnitude path; no special case is needed.
- start is ignored while busy=1; no queuing.
- A start asserted in the same cycle as done is not accepted, because the state is still FIXUP. It is accepted on the next edge if still high.
- HI and LO change only at the FIXUP edge or on reset. Between operations they hold the last result.
- Ra and Rb may change freely after the start edge.

Optional Feature:
- Macro: SEQ_DIV_DIVZERO_EN.
- Defined:
  - adds output port div_zero (1 bit, reset 0);
  - when dz is captured at the start edge, the block skips RUN and goes straight to FIXUP;
  - done and div_zero pulse together after edge 2 (2-cycle latency), with the same HI/LO values as the normal dz case;
  - div_zero is 0 with every non-zero-divisor done.
- Undefined: no div_zero port; a zero divisor takes the full WIDTH+1 latency and gives the dz results described above.

Test Plan:
- Assert clear for 2 cycles mid-RUN (start Ra=100, Rb=7, clear at edge 10) -> busy=0, done never pulses, HI=0, LO=0. A new start afterwards completes normally.
- Ra=7, Rb=2 -> done exactly 33 edges after start, LO=3, HI=1, busy high edges 0..32.
- Ra=-7, Rb=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; Ra=7, Rb=-2 -> LO=0xFFFFFFFD, HI=1; Ra=-8, Rb=-2 -> LO=4, HI=0.
- Ra=0x80000000, Rb=0xFFFFFFFF -> LO=0x80000000, HI=0; Ra=0, Rb=5 -> LO=0, HI=0.
- Ra=-5, Rb=0 -> LO=0xFFFFFFFF, HI=0xFFFFFFFB. With SEQ_DIV_DIVZERO_EN: done and div_zero are both high 2 edges after start.
- start held high continuously with Ra=9, Rb=3, then Ra=10, Rb=4 -> start is ignored during busy. The first result (LO=3, HI=0) posts, and the second operation starts on the edge after done, giving LO=2, HI=2.
